// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state and operation
// encodings, widths, and the byte-address to word-index helper.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  // Word index of a byte address (drops the two byte-offset bits).
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// DEPTH x 32 word storage: one synchronous write port and one registered,
// enable-gated read port. Contents have no reset.
module mem_word_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: commit one word per enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: register the addressed word only when asked, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor data port. Captures a read/write
// request in IDLE, waits WAIT_STATES cycles, then pulses mem_ready for one cycle.
//
// Handshake: ctrl_mem_read/ctrl_mem_write are levels sampled only in IDLE; the
// request is taken on the edge it is seen, later input changes are ignored, and
// completion is the single-cycle mem_ready (with mem_err on rejection). A request
// still held when the FSM is back in IDLE is taken as a new request.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_mem_read,
  input  logic        ctrl_mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy,
  output state_t      state_dbg
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;

  // Captured request
  op_t                 cap_op;
  logic                cap_err;
  logic [AW-1:0]       cap_idx;
  logic [WORD_W-1:0]   cap_data;

  // Decoded live inputs
  logic                req;
  logic [29:0]         in_idx_full;
  op_t                 in_op;
  logic                in_err;
  logic                capture;

  // Operation as seen on the edge entering RESP (live inputs when coming
  // straight from IDLE, captured values otherwise)
  op_t                 cur_op;
  logic                cur_err;
  logic [AW-1:0]       cur_idx;
  logic [WORD_W-1:0]   cur_data;
  logic                enter_resp;

  logic                ram_we;
  logic                ram_re;
  logic [WORD_W-1:0]   ram_rdata;
  logic                out_zero;

  // Decode the live request: operation code and the three rejection causes.
  always_comb begin
    req         = ctrl_mem_read | ctrl_mem_write;
    in_idx_full = word_index(data_addr);
    in_op       = OP_NONE;
    if (ctrl_mem_read && !ctrl_mem_write) in_op = OP_READ;
    else if (ctrl_mem_write && !ctrl_mem_read) in_op = OP_WRITE;
    in_err = (ctrl_mem_read && ctrl_mem_write) ||
             (data_addr[1:0] != 2'b00) ||
             (in_idx_full >= 30'(DEPTH));
    capture = (state == ST_IDLE) && req;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> WAIT/RESP on request, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 4'd1) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait counter and request capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      cap_op   <= OP_NONE;
      cap_err  <= 1'b0;
      cap_idx  <= '0;
      cap_data <= '0;
    end else if (capture) begin
      cnt      <= WS_LOAD;
      cap_op   <= in_op;
      cap_err  <= in_err;
      cap_idx  <= in_idx_full[AW-1:0];
      cap_data <= data_in;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Select the operation that completes on the edge entering RESP.
  always_comb begin
    enter_resp = (state_next == ST_RESP);
    if (state == ST_IDLE) begin
      cur_op   = in_op;
      cur_err  = in_err;
      cur_idx  = in_idx_full[AW-1:0];
      cur_data = data_in;
    end else begin
      cur_op   = cap_op;
      cur_err  = cap_err;
      cur_idx  = cap_idx;
      cur_data = cap_data;
    end
    ram_we = enter_resp && (cur_op == OP_WRITE) && !cur_err;
    ram_re = enter_resp && (cur_op == OP_READ) && !cur_err;
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_idx),
    .wdata (cur_data),
    .re    (ram_re),
    .raddr (cur_idx),
    .rdata (ram_rdata)
  );

  // Read-data mask: forces data_out to zero after reset and after a rejected read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_zero <= 1'b1;
    else if (enter_resp && cur_op == OP_READ) out_zero <= cur_err;
  end

  // Moore outputs decoded from registered state and captured flags.
  always_comb begin
    mem_ready = (state == ST_RESP);
    mem_err   = (state == ST_RESP) && cap_err;
    busy      = (state != ST_IDLE);
    data_out  = out_zero ? '0 : ram_rdata;
    state_dbg = state;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none, driven from a single sequence with hand-computed expectations.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance with WAIT_STATES=2 (suffix 2) and WAIT_STATES=0 (suffix 0)
  logic        rd2 = 1'b0, wr2 = 1'b0;
  logic [31:0] addr2 = '0, din2 = '0;
  logic [31:0] dout2;
  logic        rdy2, err2, bsy2;
  state_t      st2;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, din0 = '0;
  logic [31:0] dout0;
  logic        rdy0, err0, bsy0;
  state_t      st0;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset),
    .ctrl_mem_read(rd2), .ctrl_mem_write(wr2),
    .data_addr(addr2), .data_in(din2),
    .data_out(dout2), .mem_ready(rdy2), .mem_err(err2), .busy(bsy2),
    .state_dbg(st2)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset),
    .ctrl_mem_read(rd0), .ctrl_mem_write(wr0),
    .data_addr(addr0), .data_in(din0),
    .data_out(dout0), .mem_ready(rdy0), .mem_err(err0), .busy(bsy0),
    .state_dbg(st0)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (which == 2) begin
      rd2 = r; wr2 = w; addr2 = a; din2 = d;
    end else begin
      rd0 = r; wr0 = w; addr0 = a; din0 = d;
    end
  endtask

  function automatic logic get_rdy(input int which);
    return (which == 2) ? rdy2 : rdy0;
  endfunction
  function automatic logic get_err(input int which);
    return (which == 2) ? err2 : err0;
  endfunction
  function automatic logic get_bsy(input int which);
    return (which == 2) ? bsy2 : bsy0;
  endfunction
  function automatic logic [31:0] get_dout(input int which);
    return (which == 2) ? dout2 : dout0;
  endfunction
  function automatic logic [1:0] get_st(input int which);
    return (which == 2) ? st2 : st0;
  endfunction

  // One request: drive at a negedge, hold until mem_ready, then release.
  // Optionally changes address/data in the first cycle after capture.
  task automatic req(input int which, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic exp_err,
                     input logic chk_data, input logic [31:0] exp_data,
                     input logic chg, input logic [31:0] ca, input logic [31:0] cd,
                     input string tag);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    drive(which, r, w, a, d);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_busy"}, {31'b0, get_bsy(which)}, 32'd1);
        check({tag, "_state"}, {30'b0, get_st(which)},
              (which == 2) ? {30'b0, ST_WAIT} : {30'b0, ST_RESP});
        if (chg) drive(which, r, w, ca, cd);
      end
      if (get_rdy(which)) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, "_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_err"}, {31'b0, get_err(which)}, {31'b0, exp_err});
      if (chk_data) check({tag, "_data"}, get_dout(which), exp_data);
    end
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, get_rdy(which)}, 32'd0);
    check({tag, "_idle"}, {31'b0, get_bsy(which)}, 32'd0);
  endtask

  task automatic wr_ok(input int which, input logic [31:0] a, input logic [31:0] d, input string tag);
    req(which, 1'b0, 1'b1, a, d, (which == 2) ? 3 : 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, tag);
  endtask

  task automatic rd_chk(input int which, input logic [31:0] a, input logic exp_err,
                        input logic [31:0] exp_data, input string tag);
    req(which, 1'b1, 1'b0, a, 32'h0, (which == 2) ? 3 : 1, exp_err, 1'b1, exp_data,
        1'b0, 32'h0, 32'h0, tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- sequence ----------------
  initial begin
    logic [5:0] pattern;
    bit         saw;

    // Reset state
    @(negedge clk);
    check("rst_dout", dout2, 32'h0);
    check("rst_ready", {31'b0, rdy2}, 32'd0);
    check("rst_err", {31'b0, err2}, 32'd0);
    check("rst_busy", {31'b0, bsy2}, 32'd0);
    check("rst_state", {30'b0, st2}, {30'b0, ST_IDLE});
    check("rst_dout_ws0", dout0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // WAIT_STATES=2: write then read back
    wr_ok(2, 32'h10, 32'hDEADBEEF, "ws2_wr10");
    rd_chk(2, 32'h10, 1'b0, 32'hDEADBEEF, "ws2_rd10");

    // WAIT_STATES=0: single read, then a held read re-accepted every two cycles
    wr_ok(0, 32'h10, 32'hA5A50001, "ws0_wr10");
    rd_chk(0, 32'h10, 1'b0, 32'hA5A50001, "ws0_rd10");
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pattern = {pattern[4:0], rdy0};
      if (i == 4) check("ws0_held_data", dout0, 32'hA5A50001);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ws0_held_pattern", {26'b0, pattern}, 32'b101010);
    @(negedge clk);
    check("ws0_held_idle", {31'b0, bsy0}, 32'd0);

    // Error cases on the WAIT_STATES=2 instance
    wr_ok(2, 32'h0, 32'h44444444, "ws2_wr00");
    wr_ok(2, 32'h20, 32'h11111111, "ws2_wr20");
    req(2, 1'b1, 1'b1, 32'h20, 32'h22222222, 3, 1'b1, 1'b1, 32'hDEADBEEF,
        1'b0, 32'h0, 32'h0, "err_rdwr");
    rd_chk(2, 32'h20, 1'b0, 32'h11111111, "err_rdwr_after");
    rd_chk(2, 32'h13, 1'b1, 32'h0, "err_misalign_rd");
    req(2, 1'b0, 1'b1, 32'h400, 32'h33333333, 3, 1'b1, 1'b0, 32'h0,
        1'b0, 32'h0, 32'h0, "err_range_wr");
    rd_chk(2, 32'h0, 1'b0, 32'h44444444, "err_range_noalias");
    rd_chk(2, 32'h400, 1'b1, 32'h0, "err_range_rd");
    rd_chk(2, 32'h80000000, 1'b1, 32'h0, "err_high_rd");
    req(2, 1'b0, 1'b1, 32'h22, 32'h55555555, 3, 1'b1, 1'b0, 32'h0,
        1'b0, 32'h0, 32'h0, "err_misalign_wr");
    rd_chk(2, 32'h20, 1'b0, 32'h11111111, "err_misalign_nowr");

    // Reset asserted mid-cycle while a read response is on the outputs
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_resp_ready_before", {31'b0, rdy2}, 32'd1);
    check("rst_resp_data_before", dout2, 32'hDEADBEEF);
    reset = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_async_dout", dout2, 32'h0);
    check("rst_async_ready", {31'b0, rdy2}, 32'd0);
    check("rst_async_err", {31'b0, err2}, 32'd0);
    check("rst_async_busy", {31'b0, bsy2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during WAIT of a write: nothing commits, no ready pulse
    wr_ok(2, 32'h40, 32'h0BADF00D, "ws2_wr40");
    drive(2, 1'b0, 1'b1, 32'h40, 32'h12345678);
    @(negedge clk);
    check("rst_wait_busy", {31'b0, bsy2}, 32'd1);
    reset = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      if (rdy2) saw = 1'b1;
    end
    check("rst_wait_noready", {31'b0, saw}, 32'd0);
    rd_chk(2, 32'h40, 1'b0, 32'h0BADF00D, "rst_wait_nowr");

    // Inputs changed during WAIT do not affect the in-flight operation
    wr_ok(2, 32'h64, 32'h99999999, "ws2_wr64");
    req(2, 1'b0, 1'b1, 32'h60, 32'h77777777, 3, 1'b0, 1'b0, 32'h0,
        1'b1, 32'h64, 32'h88888888, "chg_wr");
    rd_chk(2, 32'h60, 1'b0, 32'h77777777, "chg_rd60");
    rd_chk(2, 32'h64, 1'b0, 32'h99999999, "chg_rd64");
    req(2, 1'b1, 1'b0, 32'h60, 32'h0, 3, 1'b0, 1'b1, 32'h77777777,
        1'b1, 32'h64, 32'h0, "chg_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
